// File: rtl/tetris_keys_pkg.sv
// Shared keyboard definitions for the key command encoder and the block mover:
// HID keycodes, keypress command encoding and encoder FSM states.
package tetris_keys_pkg;

  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_S     = 8'h16;
  localparam logic [7:0] KC_SPACE = 8'h2C;
  localparam logic [7:0] KC_ENTER = 8'h28;

  localparam logic [1:0]  GS_PLAYING = 2'd2;
  localparam logic [27:0] CNT_MAX    = 28'hFFF_FFFF;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_LEFT  = 3'd1,
    CMD_RIGHT = 3'd2,
    CMD_SOFT  = 3'd3,
    CMD_HARD  = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_GAP      = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_e;

  // Enter is not a move command, so it maps to CMD_NONE like any unmapped code.
  function automatic cmd_e map_key(input logic [7:0] code);
    cmd_e cmd;
    case (code)
      KC_A:     cmd = CMD_LEFT;
      KC_D:     cmd = CMD_RIGHT;
      KC_S:     cmd = CMD_SOFT;
      KC_SPACE: cmd = CMD_HARD;
      default:  cmd = CMD_NONE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/key_stabilizer.sv
// Keycode press filter: a code is accepted only after it has been sampled
// unchanged for STABLE_CYCLES consecutive edges.
module key_stabilizer
  import tetris_keys_pkg::*;
#(
  parameter logic [27:0] STABLE_CYCLES = 28'd4096
) (
  input  logic       decis_clk,
  input  logic       Reset,
  input  logic       reset_game,
  input  logic [7:0] keycode,
  output logic [7:0] acc_code
);

  logic [7:0]  kc_q_r;
  logic [27:0] stab_cnt_r;
  logic [7:0]  acc_code_r;

  // Sample register, saturating stability counter and accepted-code register.
  always_ff @(posedge decis_clk or posedge Reset) begin
    if (Reset) begin
      kc_q_r     <= 8'd0;
      stab_cnt_r <= 28'd0;
      acc_code_r <= 8'd0;
    end else if (reset_game) begin
      kc_q_r     <= 8'd0;
      stab_cnt_r <= 28'd0;
      acc_code_r <= 8'd0;
    end else begin
      kc_q_r <= keycode;
      if (keycode != kc_q_r) begin
        stab_cnt_r <= 28'd0;
      end else if (stab_cnt_r != CNT_MAX) begin
        stab_cnt_r <= stab_cnt_r + 28'd1;
      end else begin
        stab_cnt_r <= stab_cnt_r;
      end
      if (stab_cnt_r == STABLE_CYCLES - 28'd1) begin
        acc_code_r <= kc_q_r;
      end else begin
        acc_code_r <= acc_code_r;
      end
    end
  end

  assign acc_code = acc_code_r;

endmodule

// File: rtl/key_command_encoder.sv
// Turns the filtered HID keycode into timed keypress pulses with auto-repeat
// and one-shot hard drop, plus a start pulse on Enter for the game FSM.
module key_command_encoder
  import tetris_keys_pkg::*;
#(
  parameter logic [27:0] STABLE_CYCLES = 28'd4096,
  parameter logic [27:0] PULSE_LEN     = 28'h0100000,
  parameter logic [27:0] REPEAT_DELAY  = 28'h0800000,
  parameter logic [27:0] REPEAT_RATE   = 28'h0200000
) (
  input  logic       decis_clk,
  input  logic       Reset,
  input  logic       reset_game,
  input  logic [1:0] gamestate,
  input  logic [7:0] keycode,
  output logic [2:0] keypress,
  output logic       start_pulse,
  output logic       busy
);

  logic [7:0]  acc_code_s;
  cmd_e        acc_cmd_s;
  logic        playing_s;
  logic [27:0] cnt_inc_s;
  logic [27:0] gap_end_s;

  state_e      state_r, state_n;
  cmd_e        cmd_r, cmd_n;
  logic [27:0] cnt_r, cnt_n;
  logic        first_r, first_n;
  cmd_e        keypress_r;
  logic        start_pulse_r;
  logic [7:0]  acc_prev_r;

  key_stabilizer #(.STABLE_CYCLES(STABLE_CYCLES)) u_stab (
    .decis_clk  (decis_clk),
    .Reset      (Reset),
    .reset_game (reset_game),
    .keycode    (keycode),
    .acc_code   (acc_code_s)
  );

  assign acc_cmd_s = map_key(acc_code_s);
  assign playing_s = (gamestate == GS_PLAYING);
  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + 28'd1;
  assign gap_end_s = (first_r ? REPEAT_DELAY : REPEAT_RATE) - 28'd1;

  // Next-state logic; cmd_r doubles as the key that must be released in WAIT_REL.
  always_comb begin
    state_n = state_r;
    cmd_n   = cmd_r;
    cnt_n   = cnt_r;
    first_n = first_r;
    if (!playing_s) begin
      cnt_n = 28'd0;
      if (acc_cmd_s != CMD_NONE) begin
        state_n = ST_WAIT_REL;
        cmd_n   = acc_cmd_s;
      end else begin
        state_n = ST_IDLE;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (acc_cmd_s != CMD_NONE) begin
            state_n = ST_ISSUE;
            cmd_n   = acc_cmd_s;
            cnt_n   = 28'd0;
            first_n = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (cnt_r == PULSE_LEN - 28'd1) begin
            state_n = (cmd_r == CMD_HARD) ? ST_WAIT_REL : ST_GAP;
            cnt_n   = 28'd0;
          end else begin
            cnt_n = cnt_inc_s;
          end
        end
        ST_GAP: begin
          if (acc_cmd_s == CMD_NONE) begin
            state_n = ST_IDLE;
          end else if (acc_cmd_s != cmd_r) begin
            state_n = ST_ISSUE;
            cmd_n   = acc_cmd_s;
            cnt_n   = 28'd0;
            first_n = 1'b1;
          end else if (cnt_r == gap_end_s) begin
            state_n = ST_ISSUE;
            cnt_n   = 28'd0;
            first_n = 1'b0;
          end else begin
            cnt_n = cnt_inc_s;
          end
        end
        ST_WAIT_REL: begin
          if (acc_cmd_s == cmd_r) begin
            state_n = ST_WAIT_REL;
          end else if (acc_cmd_s != CMD_NONE) begin
            state_n = ST_ISSUE;
            cmd_n   = acc_cmd_s;
            cnt_n   = 28'd0;
            first_n = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = 28'd0;
        end
      endcase
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge decis_clk or posedge Reset) begin
    if (Reset) begin
      state_r       <= ST_IDLE;
      cmd_r         <= CMD_NONE;
      cnt_r         <= 28'd0;
      first_r       <= 1'b0;
      keypress_r    <= CMD_NONE;
      start_pulse_r <= 1'b0;
      acc_prev_r    <= 8'd0;
    end else if (reset_game) begin
      state_r       <= ST_IDLE;
      cmd_r         <= CMD_NONE;
      cnt_r         <= 28'd0;
      first_r       <= 1'b0;
      keypress_r    <= CMD_NONE;
      start_pulse_r <= 1'b0;
      acc_prev_r    <= 8'd0;
    end else begin
      state_r       <= state_n;
      cmd_r         <= cmd_n;
      cnt_r         <= cnt_n;
      first_r       <= first_n;
      keypress_r    <= (state_n == ST_ISSUE) ? cmd_n : CMD_NONE;
      start_pulse_r <= (acc_code_s == KC_ENTER) && (acc_prev_r != KC_ENTER);
      acc_prev_r    <= acc_code_s;
    end
  end

  // Leaving play must silence the bus in the same cycle, hence the combinational gate.
  assign keypress    = playing_s ? keypress_r : 3'd0;
  assign start_pulse = start_pulse_r;
  assign busy        = (state_r != ST_IDLE);

endmodule

// File: tb/tb_key_command_encoder.sv
// Directed, table-driven bench for key_command_encoder with short timing
// parameters; expected outputs are hand-derived per clock edge.
module tb_key_command_encoder;

  logic       decis_clk = 1'b0;
  logic       Reset;
  logic       reset_game;
  logic [1:0] gamestate;
  logic [7:0] keycode;
  logic [2:0] keypress;
  logic       start_pulse;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0] gs;
    logic [7:0] kc;
    logic       rg;
    logic [2:0] kp;
    logic       sp;
    logic       bz;
  } vec_t;

  vec_t vecs[$];

  key_command_encoder #(
    .STABLE_CYCLES (28'd2),
    .PULSE_LEN     (28'd4),
    .REPEAT_DELAY  (28'd10),
    .REPEAT_RATE   (28'd6)
  ) dut (
    .decis_clk   (decis_clk),
    .Reset       (Reset),
    .reset_game  (reset_game),
    .gamestate   (gamestate),
    .keycode     (keycode),
    .keypress    (keypress),
    .start_pulse (start_pulse),
    .busy        (busy)
  );

  always #5 decis_clk = ~decis_clk;

  function automatic void add(input logic [1:0] gs, input logic [7:0] kc, input logic rg,
                              input logic [2:0] kp, input logic sp, input logic bz, input int n);
    vec_t v;
    v.gs = gs; v.kc = kc; v.rg = rg; v.kp = kp; v.sp = sp; v.bz = bz;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge decis_clk);
    #1;
  endtask

  initial begin
    // Held A: pulse after edges 3..6, then 10 off, 4 on, 6 off, 4 on ...
    add(2'd2, 8'h04, 1'b0, 3'd0, 1'b0, 1'b0, 3);
    add(2'd2, 8'h04, 1'b0, 3'd1, 1'b0, 1'b1, 4);
    add(2'd2, 8'h04, 1'b0, 3'd0, 1'b0, 1'b1, 10);
    add(2'd2, 8'h04, 1'b0, 3'd1, 1'b0, 1'b1, 4);
    add(2'd2, 8'h04, 1'b0, 3'd0, 1'b0, 1'b1, 6);
    add(2'd2, 8'h04, 1'b0, 3'd1, 1'b0, 1'b1, 4);
    add(2'd2, 8'h04, 1'b0, 3'd0, 1'b0, 1'b1, 6);
    add(2'd2, 8'h04, 1'b0, 3'd1, 1'b0, 1'b1, 4);
    add(2'd2, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 3);
    add(2'd2, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 3);
    // Space held 50 cycles: a single hard-drop pulse, then release and re-press
    add(2'd2, 8'h2C, 1'b0, 3'd0, 1'b0, 1'b0, 3);
    add(2'd2, 8'h2C, 1'b0, 3'd4, 1'b0, 1'b1, 4);
    add(2'd2, 8'h2C, 1'b0, 3'd0, 1'b0, 1'b1, 43);
    add(2'd2, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 3);
    add(2'd2, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 3);
    add(2'd2, 8'h2C, 1'b0, 3'd0, 1'b0, 1'b0, 3);
    add(2'd2, 8'h2C, 1'b0, 3'd4, 1'b0, 1'b1, 4);
    add(2'd2, 8'h2C, 1'b0, 3'd0, 1'b0, 1'b1, 3);
    add(2'd2, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 3);
    add(2'd2, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 3);
    // One-cycle D is filtered out
    add(2'd2, 8'h07, 1'b0, 3'd0, 1'b0, 1'b0, 1);
    add(2'd2, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 6);
    // Held D with a one-cycle glitch in the first gap: repeat timing unchanged
    add(2'd2, 8'h07, 1'b0, 3'd0, 1'b0, 1'b0, 3);
    add(2'd2, 8'h07, 1'b0, 3'd2, 1'b0, 1'b1, 4);
    add(2'd2, 8'h07, 1'b0, 3'd0, 1'b0, 1'b1, 1);
    add(2'd2, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1);
    add(2'd2, 8'h07, 1'b0, 3'd0, 1'b0, 1'b1, 8);
    add(2'd2, 8'h07, 1'b0, 3'd2, 1'b0, 1'b1, 4);
    add(2'd2, 8'h07, 1'b0, 3'd0, 1'b0, 1'b1, 2);
    add(2'd2, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 3);
    add(2'd2, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 3);
    // A -> D at pulse cycle 2: left completes, one zero cycle, right pulse
    add(2'd2, 8'h04, 1'b0, 3'd0, 1'b0, 1'b0, 3);
    add(2'd2, 8'h04, 1'b0, 3'd1, 1'b0, 1'b1, 2);
    add(2'd2, 8'h07, 1'b0, 3'd1, 1'b0, 1'b1, 2);
    add(2'd2, 8'h07, 1'b0, 3'd0, 1'b0, 1'b1, 1);
    add(2'd2, 8'h07, 1'b0, 3'd2, 1'b0, 1'b1, 4);
    add(2'd2, 8'h07, 1'b0, 3'd0, 1'b0, 1'b1, 10);
    add(2'd2, 8'h07, 1'b0, 3'd2, 1'b0, 1'b1, 4);
    add(2'd2, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 3);
    add(2'd2, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 3);
    // Leave play mid-pulse; key held across return to play needs a release
    add(2'd2, 8'h04, 1'b0, 3'd0, 1'b0, 1'b0, 3);
    add(2'd2, 8'h04, 1'b0, 3'd1, 1'b0, 1'b1, 2);
    add(2'd0, 8'h04, 1'b0, 3'd0, 1'b0, 1'b1, 3);
    add(2'd2, 8'h04, 1'b0, 3'd0, 1'b0, 1'b1, 10);
    add(2'd2, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 3);
    add(2'd2, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 2);
    add(2'd2, 8'h04, 1'b0, 3'd0, 1'b0, 1'b0, 3);
    add(2'd2, 8'h04, 1'b0, 3'd1, 1'b0, 1'b1, 4);
    add(2'd2, 8'h04, 1'b0, 3'd0, 1'b0, 1'b1, 2);
    add(2'd2, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 3);
    add(2'd2, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 3);
    // reset_game mid-pulse clears the filter too, so the held key re-qualifies
    add(2'd2, 8'h04, 1'b0, 3'd0, 1'b0, 1'b0, 3);
    add(2'd2, 8'h04, 1'b0, 3'd1, 1'b0, 1'b1, 1);
    add(2'd2, 8'h04, 1'b1, 3'd0, 1'b0, 1'b0, 1);
    add(2'd2, 8'h04, 1'b0, 3'd0, 1'b0, 1'b0, 3);
    add(2'd2, 8'h04, 1'b0, 3'd1, 1'b0, 1'b1, 4);
    add(2'd2, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 3);
    add(2'd2, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 3);
    // Enter while not playing: one start pulse; again after release
    add(2'd0, 8'h28, 1'b0, 3'd0, 1'b0, 1'b0, 3);
    add(2'd0, 8'h28, 1'b0, 3'd0, 1'b1, 1'b0, 1);
    add(2'd0, 8'h28, 1'b0, 3'd0, 1'b0, 1'b0, 6);
    add(2'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 4);
    add(2'd2, 8'h28, 1'b0, 3'd0, 1'b0, 1'b0, 3);
    add(2'd2, 8'h28, 1'b0, 3'd0, 1'b1, 1'b0, 1);
    add(2'd2, 8'h28, 1'b0, 3'd0, 1'b0, 1'b0, 3);
    add(2'd2, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 4);

    Reset      = 1'b1;
    reset_game = 1'b0;
    gamestate  = 2'd2;
    keycode    = 8'h00;
    repeat (3) @(posedge decis_clk);
    #1;
    check("reset keypress", {5'd0, keypress}, 8'd0);
    check("reset start_pulse", {7'd0, start_pulse}, 8'd0);
    check("reset busy", {7'd0, busy}, 8'd0);
    @(negedge decis_clk);
    Reset = 1'b0;

    foreach (vecs[i]) begin
      gamestate  = vecs[i].gs;
      keycode    = vecs[i].kc;
      reset_game = vecs[i].rg;
      tick();
      check($sformatf("vec%0d keypress", i), {5'd0, keypress}, {5'd0, vecs[i].kp});
      check($sformatf("vec%0d start_pulse", i), {7'd0, start_pulse}, {7'd0, vecs[i].sp});
      check($sformatf("vec%0d busy", i), {7'd0, busy}, {7'd0, vecs[i].bz});
    end
    reset_game = 1'b0;

    // Dropping out of play gates keypress within the same cycle
    gamestate = 2'd2;
    keycode   = 8'h04;
    repeat (4) tick();
    check("gate pre keypress", {5'd0, keypress}, 8'd1);
    gamestate = 2'd0;
    #1;
    check("gate same-cycle keypress", {5'd0, keypress}, 8'd0);
    tick();
    check("gate wait_rel busy", {7'd0, busy}, 8'd1);
    check("gate wait_rel keypress", {5'd0, keypress}, 8'd0);
    gamestate = 2'd2;
    keycode   = 8'h00;
    repeat (4) tick();
    check("gate released busy", {7'd0, busy}, 8'd0);

    // Asynchronous Reset in the middle of a pulse
    keycode = 8'h04;
    repeat (4) tick();
    check("areset pre keypress", {5'd0, keypress}, 8'd1);
    check("areset pre busy", {7'd0, busy}, 8'd1);
    #2;
    Reset = 1'b1;
    #1;
    check("areset keypress", {5'd0, keypress}, 8'd0);
    check("areset busy", {7'd0, busy}, 8'd0);
    check("areset start_pulse", {7'd0, start_pulse}, 8'd0);
    @(negedge decis_clk);
    Reset   = 1'b0;
    keycode = 8'h00;
    repeat (3) tick();
    check("post reset busy", {7'd0, busy}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
